// File: rtl/data_memory_store_arbiter_if.sv
// Store/load-hazard bus between the two cores and the data-memory store arbiter,
// plus the arbiter's single write port toward the shared data memory.
interface data_memory_store_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              st_valid_0;
    logic              st_ready_0;
    logic [ADDR_W-1:0] st_addr_0;
    logic [DATA_W-1:0] st_data_0;
    logic [ADDR_W-1:0] ld_addr_0;
    logic              hazard_0;

    logic              st_valid_1;
    logic              st_ready_1;
    logic [ADDR_W-1:0] st_addr_1;
    logic [DATA_W-1:0] st_data_1;
    logic [ADDR_W-1:0] ld_addr_1;
    logic              hazard_1;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_src;
    logic              idle;

    modport master (
        output st_valid_0, st_addr_0, st_data_0, ld_addr_0,
        output st_valid_1, st_addr_1, st_data_1, ld_addr_1,
        input  st_ready_0, hazard_0, st_ready_1, hazard_1,
        input  mem_we, mem_addr, mem_wdata, mem_src, idle
    );

    modport slave (
        input  st_valid_0, st_addr_0, st_data_0, ld_addr_0,
        input  st_valid_1, st_addr_1, st_data_1, ld_addr_1,
        output st_ready_0, hazard_0, st_ready_1, hazard_1,
        output mem_we, mem_addr, mem_wdata, mem_src, idle
    );
endinterface

// File: rtl/data_memory_store_arbiter.sv
// Two per-core store buffers drained round-robin onto the data memory's single write port;
// core-1 addresses are relocated into the upper half and pending stores raise load hazards.
module data_memory_store_arbiter #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned CORE1_OFFSET = 128
) (
    input logic                           clk,
    input logic                           reset,
    data_memory_store_arbiter_if.slave    bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] OFFSET = ADDR_W'(CORE1_OFFSET);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [1:0]        st_valid;
    logic [ADDR_W-1:0] st_addr [2];
    logic [DATA_W-1:0] st_data [2];
    logic [ADDR_W-1:0] ld_addr [2];

    logic [ADDR_W-1:0] buf_addr_q [2][DEPTH];
    logic [DATA_W-1:0] buf_data_q [2][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [2];
    logic [PTR_W-1:0]  rd_ptr_q [2];
    logic [CNT_W-1:0]  count_q [2];

    logic              last_grant_q;
    logic              mem_we_q;
    logic              mem_src_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic [1:0]        ready;
    logic [1:0]        non_empty;
    logic [1:0]        push;
    logic [1:0]        pop;
    logic              grant_valid;
    logic              grant_core;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [ADDR_W-1:0] phys_addr;
    logic [1:0]        hazard;
    logic [PTR_W-1:0]  slot;
    logic [ADDR_W-1:0] ld_phys;

    assign st_valid   = {bus.st_valid_1, bus.st_valid_0};
    assign st_addr[0] = bus.st_addr_0;
    assign st_addr[1] = bus.st_addr_1;
    assign st_data[0] = bus.st_data_0;
    assign st_data[1] = bus.st_data_1;
    assign ld_addr[0] = bus.ld_addr_0;
    assign ld_addr[1] = bus.ld_addr_1;

    // Ready depends only on registered counts, so no st_valid -> st_ready path exists.
    always_comb begin
        ready     = '0;
        non_empty = '0;
        push      = '0;
        for (int c = 0; c < 2; c++) begin
            ready[c]     = (count_q[c] != FULL_COUNT);
            non_empty[c] = (count_q[c] != '0);
            push[c]      = st_valid[c] && ready[c];
        end
    end

    always_comb begin
        grant_valid = |non_empty;
        if (&non_empty) begin
            grant_core = ~last_grant_q;
        end else begin
            grant_core = non_empty[1];
        end
        pop[0]    = grant_valid && !grant_core;
        pop[1]    = grant_valid && grant_core;
        head_addr = buf_addr_q[grant_core][rd_ptr_q[grant_core]];
        head_data = buf_data_q[grant_core][rd_ptr_q[grant_core]];
        phys_addr = head_addr + (grant_core ? OFFSET : '0);
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        hazard  = '0;
        slot    = '0;
        ld_phys = '0;
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot = PTR_W'(i) - rd_ptr_q[c];
                if ((CNT_W'(slot) < count_q[c]) && (buf_addr_q[c][i] == ld_addr[c])) begin
                    hazard[c] = 1'b1;
                end
            end
            ld_phys = ld_addr[c] + ((c == 1) ? OFFSET : '0);
            if (mem_we_q && (mem_src_q == 1'(c)) && (ld_phys == mem_addr_q)) begin
                hazard[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                count_q[c]  <= '0;
            end
            last_grant_q <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_src_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (push[c]) begin
                    buf_addr_q[c][wr_ptr_q[c]] <= st_addr[c];
                    buf_data_q[c][wr_ptr_q[c]] <= st_data[c];
                    wr_ptr_q[c]                <= wr_ptr_q[c] + PTR_W'(1);
                end
                if (pop[c]) begin
                    rd_ptr_q[c] <= rd_ptr_q[c] + PTR_W'(1);
                end
                if (push[c] && !pop[c]) begin
                    count_q[c] <= count_q[c] + CNT_W'(1);
                end else if (pop[c] && !push[c]) begin
                    count_q[c] <= count_q[c] - CNT_W'(1);
                end
            end
            mem_we_q <= grant_valid;
            if (grant_valid) begin
                last_grant_q <= grant_core;
                mem_src_q    <= grant_core;
                mem_addr_q   <= phys_addr;
                mem_wdata_q  <= head_data;
            end
        end
    end

    assign bus.st_ready_0 = ready[0];
    assign bus.st_ready_1 = ready[1];
    assign bus.hazard_0   = hazard[0];
    assign bus.hazard_1   = hazard[1];
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_src    = mem_src_q;
    assign bus.idle       = (count_q[0] == '0) && (count_q[1] == '0) && !mem_we_q;
endmodule

// File: tb/tb_data_memory_store_arbiter.sv
// Directed bench for data_memory_store_arbiter: hand-computed expectations checked with
// immediate assertions one clock phase after each rising edge.
module tb_data_memory_store_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    data_memory_store_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    data_memory_store_arbiter #(
        .ADDR_W       (8),
        .DATA_W       (8),
        .DEPTH        (2),
        .CORE1_OFFSET (128)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("assertion on %s", tag);
        end
    endtask

    task automatic check_mem(input string tag, input logic [7:0] a, input logic [7:0] d,
                             input logic s);
        check({tag, "_we"}, 32'(bus.mem_we), 32'(1));
        check({tag, "_addr"}, 32'(bus.mem_addr), 32'(a));
        check({tag, "_wdata"}, 32'(bus.mem_wdata), 32'(d));
        check({tag, "_src"}, 32'(bus.mem_src), 32'(s));
    endtask

    task automatic set0(input logic v, input logic [7:0] a, input logic [7:0] d);
        bus.st_valid_0 = v;
        bus.st_addr_0  = a;
        bus.st_data_0  = d;
    endtask

    task automatic set1(input logic v, input logic [7:0] a, input logic [7:0] d);
        bus.st_valid_1 = v;
        bus.st_addr_1  = a;
        bus.st_data_1  = d;
    endtask

    initial begin
        reset = 1'b1;
        set0(1'b0, 8'h00, 8'h00);
        set1(1'b0, 8'h00, 8'h00);
        bus.ld_addr_0 = 8'h00;
        bus.ld_addr_1 = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_we", 32'(bus.mem_we), 32'(0));
        check("rst_addr", 32'(bus.mem_addr), 32'(0));
        check("rst_wdata", 32'(bus.mem_wdata), 32'(0));
        check("rst_src", 32'(bus.mem_src), 32'(0));
        check("rst_ready0", 32'(bus.st_ready_0), 32'(1));
        check("rst_ready1", 32'(bus.st_ready_1), 32'(1));
        check("rst_idle", 32'(bus.idle), 32'(1));
        check("rst_hazard0", 32'(bus.hazard_0), 32'(0));

        // Single core-0 store: pushed at edge k, written during k+1..k+2.
        set0(1'b1, 8'h05, 8'hA5);
        tick();
        set0(1'b0, 8'h00, 8'h00);
        check("t1_we_k", 32'(bus.mem_we), 32'(0));
        check("t1_busy", 32'(bus.idle), 32'(0));
        tick();
        check_mem("t1_w", 8'h05, 8'hA5, 1'b0);
        tick();
        check("t1_we_done", 32'(bus.mem_we), 32'(0));
        check("t1_idle", 32'(bus.idle), 32'(1));

        // Core-1 relocation with wrap.
        set1(1'b1, 8'h10, 8'h3C);
        tick();
        set1(1'b1, 8'h90, 8'h77);
        tick();
        set1(1'b0, 8'h00, 8'h00);
        check_mem("t2_w0", 8'h90, 8'h3C, 1'b1);
        tick();
        check_mem("t2_w1", 8'h10, 8'h77, 1'b1);
        tick();
        check("t2_idle", 32'(bus.idle), 32'(1));

        // Contention: round-robin starting with core 0.
        set0(1'b1, 8'h01, 8'h11);
        set1(1'b1, 8'h01, 8'h33);
        tick();
        set0(1'b1, 8'h02, 8'h22);
        set1(1'b1, 8'h02, 8'h44);
        tick();
        set0(1'b0, 8'h00, 8'h00);
        set1(1'b0, 8'h00, 8'h00);
        check_mem("t3_w0", 8'h01, 8'h11, 1'b0);
        tick();
        check_mem("t3_w1", 8'h81, 8'h33, 1'b1);
        tick();
        check_mem("t3_w2", 8'h02, 8'h22, 1'b0);
        tick();
        check_mem("t3_w3", 8'h82, 8'h44, 1'b1);
        tick();
        check("t3_we_done", 32'(bus.mem_we), 32'(0));
        check("t3_idle", 32'(bus.idle), 32'(1));

        // Core-0 buffer fills while a held core-1 stream takes alternate grants.
        set1(1'b1, 8'h41, 8'hB1);
        tick();
        check("t4_we_e1", 32'(bus.mem_we), 32'(0));
        set0(1'b1, 8'h30, 8'hC0);
        set1(1'b1, 8'h42, 8'hB2);
        tick();
        check_mem("t4_w0", 8'hC1, 8'hB1, 1'b1);
        set0(1'b1, 8'h31, 8'hC1);
        set1(1'b1, 8'h43, 8'hB3);
        tick();
        check_mem("t4_w1", 8'h30, 8'hC0, 1'b0);
        check("t4_full1", 32'(bus.st_ready_1), 32'(0));
        set0(1'b1, 8'h32, 8'hC2);
        set1(1'b1, 8'h44, 8'hB4);
        tick();
        check_mem("t4_w2", 8'hC2, 8'hB2, 1'b1);
        check("t4_full0", 32'(bus.st_ready_0), 32'(0));
        set0(1'b1, 8'h33, 8'hEE);
        tick();
        check_mem("t4_w3", 8'h31, 8'hC1, 1'b0);
        check("t4_ready0_back", 32'(bus.st_ready_0), 32'(1));
        check("t4_full1_again", 32'(bus.st_ready_1), 32'(0));
        set1(1'b0, 8'h00, 8'h00);
        tick();
        check_mem("t4_w4", 8'hC3, 8'hB3, 1'b1);
        check("t4_full0_again", 32'(bus.st_ready_0), 32'(0));
        set0(1'b0, 8'h00, 8'h00);
        tick();
        check_mem("t4_w5", 8'h32, 8'hC2, 1'b0);
        tick();
        check_mem("t4_w6", 8'hC4, 8'hB4, 1'b1);
        tick();
        check_mem("t4_w7", 8'h33, 8'hEE, 1'b0);
        tick();
        check("t4_we_done", 32'(bus.mem_we), 32'(0));
        check("t4_idle", 32'(bus.idle), 32'(1));

        // Load hazards: buffered entry, then in-flight write, per core.
        bus.ld_addr_0 = 8'h20;
        bus.ld_addr_1 = 8'h20;
        set0(1'b1, 8'h20, 8'h5A);
        #1;
        check("t5_h0_pre", 32'(bus.hazard_0), 32'(0));
        tick();
        set0(1'b0, 8'h00, 8'h00);
        #1;
        check("t5_h0_buf", 32'(bus.hazard_0), 32'(1));
        check("t5_h1_buf", 32'(bus.hazard_1), 32'(0));
        tick();
        check("t5_we", 32'(bus.mem_we), 32'(1));
        check("t5_h0_fly", 32'(bus.hazard_0), 32'(1));
        check("t5_h1_fly", 32'(bus.hazard_1), 32'(0));
        tick();
        check("t5_h0_clear", 32'(bus.hazard_0), 32'(0));
        set1(1'b1, 8'h20, 8'h6B);
        tick();
        set1(1'b0, 8'h00, 8'h00);
        #1;
        check("t5_h1_buf_c1", 32'(bus.hazard_1), 32'(1));
        check("t5_h0_buf_c1", 32'(bus.hazard_0), 32'(0));
        tick();
        check_mem("t5_w_c1", 8'hA0, 8'h6B, 1'b1);
        check("t5_h1_fly_c1", 32'(bus.hazard_1), 32'(1));
        check("t5_h0_fly_c1", 32'(bus.hazard_0), 32'(0));
        tick();
        check("t5_h1_clear", 32'(bus.hazard_1), 32'(0));

        // Reset while stores are buffered and a write is in flight.
        bus.ld_addr_0 = 8'h51;
        set0(1'b1, 8'h50, 8'h01);
        set1(1'b1, 8'h60, 8'h03);
        tick();
        set0(1'b1, 8'h51, 8'h02);
        set1(1'b1, 8'h61, 8'h04);
        tick();
        set0(1'b0, 8'h00, 8'h00);
        set1(1'b0, 8'h00, 8'h00);
        reset = 1'b1;
        #1;
        check("t6_we_pre", 32'(bus.mem_we), 32'(1));
        check("t6_busy_pre", 32'(bus.idle), 32'(0));
        check("t6_h0_pre", 32'(bus.hazard_0), 32'(1));
        tick();
        reset = 1'b0;
        #1;
        check("t6_we", 32'(bus.mem_we), 32'(0));
        check("t6_ready0", 32'(bus.st_ready_0), 32'(1));
        check("t6_ready1", 32'(bus.st_ready_1), 32'(1));
        check("t6_idle", 32'(bus.idle), 32'(1));
        check("t6_h0", 32'(bus.hazard_0), 32'(0));
        for (int n = 0; n < 3; n++) begin
            tick();
            check("t6_no_write", 32'(bus.mem_we), 32'(0));
            check("t6_still_idle", 32'(bus.idle), 32'(1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
